// File: rtl/div_unit_pkg.sv
// Shared word types and RV64M divide opcode decode for the divide front-end.
package common;
   typedef logic [63:0]  u64;
   typedef logic [127:0] u128;
endpackage

package pipes;
   typedef enum logic [2:0] {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW} div_op_t;
   typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

   function automatic logic is_word(div_op_t op);
      return op inside {DIVW, DIVUW, REMW, REMUW};
   endfunction

   function automatic logic is_signed(div_op_t op);
      return op inside {DIV, REM, DIVW, REMW};
   endfunction

   function automatic logic is_rem(div_op_t op);
      return op inside {REM, REMU, REMW, REMUW};
   endfunction
endpackage

// File: rtl/div_unit_divider.sv
// 64-bit unsigned restoring divider: loads on valid, done pulses 65 cycles later with c = {rem, quot}.
// c holds while valid stays high; dropping valid clears the core on the next edge.
module divider (
   input  logic         clk,
   input  logic         resetn,
   input  logic         valid,
   input  logic [63:0]  a,
   input  logic [63:0]  b,
   output logic         done,
   output logic [127:0] c
);
   logic [63:0] r, q;
   logic [5:0]  cnt;
   logic        run, held;
   logic [64:0] trial, diff;

   assign trial = {r, q[63]};
   assign diff  = trial - {1'b0, b};
   assign c     = {r, q};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r <= '0; q <= '0; cnt <= '0; run <= 1'b0; held <= 1'b0; done <= 1'b0;
      end else if (!valid) begin
         r <= '0; q <= '0; cnt <= '0; run <= 1'b0; held <= 1'b0; done <= 1'b0;
      end else if (!run && !held) begin
         r   <= '0;
         q   <= a;
         cnt <= '0;
         run <= 1'b1;
      end else if (run) begin
         // r < b always, so a non-negative difference fits back into 64 bits
         r   <= diff[64] ? trial[63:0] : diff[63:0];
         q   <= {q[62:0], ~diff[64]};
         cnt <= cnt + 6'd1;
         if (cnt == 6'd63) begin
            run  <= 1'b0;
            held <= 1'b1;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end
endmodule

// File: rtl/div_unit.sv
// RV64M DIV/REM front-end: sign/word prep, unsigned core, sign/word fix; done 68 cycles after start (2 for b==0).
// Pipeline stalls on busy; start is ignored while busy and flush aborts without done.
module div_unit
   import common::*;
   import pipes::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  div_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   div_state_t state, state_nx;
   div_op_t    op_q;
   u64         ua, ub, dv;
   logic       neg_q, neg_r, zero_q;
   u64         ea, eb, ma, mb;
   logic       sa, sb;
   logic       core_vld, core_done;
   u128        core_c;
   u64         quot, rem, res;

   divider u_core (
      .clk   (clk),
      .resetn(resetn),
      .valid (core_vld),
      .a     (ua),
      .b     (ub),
      .done  (core_done),
      .c     (core_c)
   );

   always_comb begin
      ea = a;
      eb = b;
      if (is_word(op)) begin
         ea = is_signed(op) ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
         eb = is_signed(op) ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
      end
      sa = is_signed(op) & ea[63];
      sb = is_signed(op) & eb[63];
      ma = sa ? -ea : ea;
      mb = sb ? -eb : eb;
   end

   always_comb begin
      state_nx = state;
      core_vld = 1'b0;
      case (state)
         IDLE: if (start) state_nx = (eb == '0) ? FIX : CALC;
         CALC: begin
            core_vld = 1'b1;
            if (core_done) state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx = IDLE;
         core_vld = 1'b0;
      end
   end

   always_comb begin
      quot = core_c[63:0];
      rem  = core_c[127:64];
      if (zero_q)
         res = is_rem(op_q) ? dv : '1;
      else if (is_rem(op_q))
         res = neg_r ? -rem : rem;
      else
         res = neg_q ? -quot : quot;
      // W results are always sign-extended from bit 31, unsigned W ops included
      if (is_word(op_q)) res = {{32{res[31]}}, res[31:0]};
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         done   <= 1'b0;
         result <= '0;
         op_q   <= DIV;
         ua     <= '0;
         ub     <= '0;
         dv     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == FIX) && !flush;
         if ((state == FIX) && !flush) result <= res;
         if ((state == IDLE) && start && !flush) begin
            op_q   <= op;
            ua     <= ma;
            ub     <= mb;
            dv     <= a;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            zero_q <= (eb == '0);
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
   import pipes::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   div_op_t     op = DIV;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [63:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_res = '0;

   always #5 clk = ~clk;

   div_unit #(.XLEN(64)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic is_w(div_op_t o);
      return o inside {DIVW, DIVUW, REMW, REMUW};
   endfunction

   // RISC-V semantics from plain signed/unsigned arithmetic
   function automatic logic [63:0] model(div_op_t o, logic [63:0] x, logic [63:0] y);
      longint      sx, sy;
      int          wx, wy;
      logic [63:0] sq, sr, uq, ur;
      logic [31:0] wsq, wsr, wuq, wur;
      logic [63:0] res;
      sx = x; sy = y; wx = x[31:0]; wy = y[31:0];
      if (y == 0) begin sq = '1; sr = x; uq = '1; ur = x; end
      else begin
         if (x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) begin sq = x; sr = '0; end
         else begin sq = sx / sy; sr = sx % sy; end
         uq = x / y; ur = x % y;
      end
      if (y[31:0] == 0) begin wsq = '1; wsr = x[31:0]; wuq = '1; wur = x[31:0]; end
      else begin
         if (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) begin wsq = x[31:0]; wsr = '0; end
         else begin wsq = wx / wy; wsr = wx % wy; end
         wuq = x[31:0] / y[31:0]; wur = x[31:0] % y[31:0];
      end
      case (o)
         DIV:     res = sq;
         DIVU:    res = uq;
         REM:     res = sr;
         REMU:    res = ur;
         DIVW:    res = {{32{wsq[31]}}, wsq};
         DIVUW:   res = {{32{wuq[31]}}, wuq};
         REMW:    res = {{32{wsr[31]}}, wsr};
         default: res = {{32{wur[31]}}, wur};
      endcase
      return res;
   endfunction

   // Issue at a negedge, return at the negedge where done is seen (start may follow at once)
   task automatic run_op(input div_op_t o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] exp, input string tag);
      int n, lat;
      logic zero;
      zero = is_w(o) ? (y[31:0] == 0) : (y == 0);
      lat  = zero ? 2 : 68;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = div_op_t'(~o); a = ~x; b = ~y;
      n = 1;
      chk({tag, " busy"}, {63'b0, busy}, 64'd1);
      chk({tag, " done early"}, {63'b0, done}, 64'd0);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " result"}, result, exp);
      chk({tag, " busy at done"}, {63'b0, busy}, 64'd0);
      last_res = exp;
   endtask

   initial begin
      #1;
      chk("reset busy", {63'b0, busy}, 64'd0);
      chk("reset done", {63'b0, done}, 64'd0);
      chk("reset result", result, 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      run_op(DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div -7/2");
      run_op(REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem -7/2");
      run_op(DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, "divu");
      run_op(REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, "remu");
      run_op(DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div ovf");
      run_op(REM,   64'h8000_0000_0000_0000, '1, 64'd0, "rem ovf");
      run_op(DIVW,  64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, "divw ovf");
      run_op(DIVU,  -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu by 0");
      run_op(REM,   -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, "rem by 0");
      run_op(REMUW, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, "remuw by 0");
      run_op(DIVUW, 64'h1_8000_0000, 64'h5_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "divuw hi-only b");

      // flush ten cycles into CALC
      op = DIVU; a = 64'd1000; b = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", {63'b0, busy}, 64'd0);
      chk("flush done", {63'b0, done}, 64'd0);
      chk("flush result held", result, last_res);
      run_op(DIVU, 64'd100, 64'd7, 64'd14, "divu after flush");

      // flush beats a simultaneous start
      op = DIV; a = 64'd50; b = 64'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("flush+start busy", {63'b0, busy}, 64'd0);
         chk("flush+start done", {63'b0, done}, 64'd0);
         @(negedge clk);
      end

      // asynchronous reset in the middle of CALC
      op = DIV; a = 64'd12345; b = 64'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("mid reset busy", {63'b0, busy}, 64'd0);
      chk("mid reset done", {63'b0, done}, 64'd0);
      chk("mid reset result", result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_op(DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "divuw after reset");

      for (int i = 0; i < 40; i++) begin
         div_op_t     o;
         logic [63:0] x, y;
         o = div_op_t'($urandom_range(0, 7));
         x = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0:       y = '0;
            1:       y = 64'($urandom_range(1, 20));
            2:       y = -64'($urandom_range(1, 20));
            3:       y = '1;
            4:       y = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: y = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 3) == 0) x = 64'h8000_0000_0000_0000 >> (32 * $urandom_range(0, 1));
         run_op(o, x, y, model(o, x, y), "random");
      end

      @(negedge clk);
      chk("final done low", {63'b0, done}, 64'd0);
      chk("final busy low", {63'b0, busy}, 64'd0);
      chk("final result held", result, last_res);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
